gsensor_sequencer: RTL and testbench

GSENSOR_SEQUENCER -- requirements
Module: gsensor_sequencer

---
 rtl/gsensor_pkg.sv | 44 ++++
 rtl/gsensor_sequencer_if.sv | 31 +++
 rtl/gsensor_tick_gen.sv | 29 ++
 rtl/gsensor_sequencer.sv | 166 ++++++++++++++++
 tb/tb_gsensor_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gsensor_pkg.sv
// Shared types and constants for the accelerometer sequencer: FSM states,
// register map, power-up configuration table and burst read length.
package gsensor_pkg;

    typedef enum logic [2:0] {
        INIT_REQ,
        INIT_WAIT,
        IDLE,
        RD_REQ,
        RD_WAIT,
        UPDATE
    } seq_state_t;

    // Accelerometer register map
    localparam logic [5:0] REG_BW_RATE     = 6'h2C;
    localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
    localparam logic [5:0] REG_INT_ENABLE  = 6'h2E;
    localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
    localparam logic [5:0] REG_DATAX0      = 6'h32;

    localparam int INIT_COUNT = 4;
    localparam int READ_COUNT = 6;

    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] data;
    } init_entry_t;

    // Configuration writes; the leftmost element is index 3, the rightmost index 0.
    // Order matters: measurement is only enabled (POWER_CTL) after format, rate
    // and interrupts are set up.
    localparam init_entry_t [INIT_COUNT-1:0] INIT_TABLE = {
        {REG_POWER_CTL,   8'h08},
        {REG_INT_ENABLE,  8'h00},
        {REG_BW_RATE,     8'h09},
        {REG_DATA_FORMAT, 8'h40}
    };

    // Address of the idx-th byte of the X0..Z1 burst
    function automatic logic [5:0] read_addr(input logic [2:0] idx);
        return REG_DATAX0 + {3'b000, idx};
    endfunction

endpackage

// File: rtl/gsensor_sequencer_if.sv
// Byte-transaction handshake between the sequencer and the SPI shifter.
interface gsensor_sequencer_if;

    logic       xfer_req;
    logic       xfer_rw;
    logic [5:0] xfer_addr;
    logic [7:0] xfer_wdata;
    logic       xfer_ack;
    logic [7:0] xfer_rdata;

    // Sequencer side: issues requests, receives completion
    modport master (
        output xfer_req,
        output xfer_rw,
        output xfer_addr,
        output xfer_wdata,
        input  xfer_ack,
        input  xfer_rdata
    );

    // Shifter side
    modport slave (
        input  xfer_req,
        input  xfer_rw,
        input  xfer_addr,
        input  xfer_wdata,
        output xfer_ack,
        output xfer_rdata
    );

endinterface

// File: rtl/gsensor_tick_gen.sv
// Free-running sample-rate divider: tick is high for one cycle every DIV cycles,
// in the cycle where the counter sits at DIV-1 (just before it wraps).
module gsensor_tick_gen #(
    parameter int DIV = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int                CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..DIV-1 and wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/gsensor_sequencer.sv
// Accelerometer sequencer: configures the sensor after reset, then on every
// sample tick reads the six data bytes as one burst and publishes X/Y/Z
// together. A missing ack aborts the burst, flags a sticky error and restarts
// the configuration from scratch.
module gsensor_sequencer
    import gsensor_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int UPDATE_FREQ = 50,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                reset_n,
    gsensor_sequencer_if.master xfer,
    output logic signed [15:0]  data_x,
    output logic signed [15:0]  data_y,
    output logic signed [15:0]  data_z,
    output logic                data_update,
    output logic                init_done,
    output logic                error
);

    localparam int               DIV      = CLK_FREQ / UPDATE_FREQ;
    localparam int               TMO_W    = $clog2(ACK_TIMEOUT + 1);
    // Last WAIT cycle in which an ack is still accepted (the ack wins a tie)
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [2:0]       INIT_LAST = 3'(INIT_COUNT - 1);
    localparam logic [2:0]       READ_LAST = 3'(READ_COUNT - 1);

    seq_state_t       state;
    logic [2:0]       idx;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tick_pending;
    logic             tick;
    logic [7:0]       shadow [READ_COUNT];

    gsensor_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // Sequencer FSM with registered bus and sample outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= INIT_REQ;
            idx             <= '0;
            tmo_cnt         <= '0;
            tick_pending    <= 1'b0;
            for (int i = 0; i < READ_COUNT; i++) begin
                shadow[i] <= '0;
            end
            xfer.xfer_req   <= 1'b0;
            xfer.xfer_rw    <= 1'b0;
            xfer.xfer_addr  <= '0;
            xfer.xfer_wdata <= '0;
            data_x          <= '0;
            data_y          <= '0;
            data_z          <= '0;
            data_update     <= 1'b0;
            init_done       <= 1'b0;
            error           <= 1'b0;
        end else begin
            data_update <= 1'b0;
            // Ticks arriving while busy collapse into one pending request
            if (tick) begin
                tick_pending <= 1'b1;
            end

            case (state)
                INIT_REQ: begin
                    xfer.xfer_req   <= 1'b1;
                    xfer.xfer_rw    <= 1'b0;
                    xfer.xfer_addr  <= INIT_TABLE[idx[1:0]].addr;
                    xfer.xfer_wdata <= INIT_TABLE[idx[1:0]].data;
                    tmo_cnt         <= '0;
                    state           <= INIT_WAIT;
                end

                INIT_WAIT: begin
                    if (xfer.xfer_ack) begin
                        xfer.xfer_req <= 1'b0;
                        if (idx == INIT_LAST) begin
                            idx       <= '0;
                            init_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= INIT_REQ;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        error         <= 1'b1;
                        xfer.xfer_req <= 1'b0;
                        init_done     <= 1'b0;
                        for (int i = 0; i < READ_COUNT; i++) begin
                            shadow[i] <= '0;
                        end
                        idx   <= '0;
                        state <= INIT_REQ;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                IDLE: begin
                    if (tick_pending) begin
                        // A tick landing in this very cycle re-arms the request
                        tick_pending <= tick;
                        idx          <= '0;
                        state        <= RD_REQ;
                    end
                end

                RD_REQ: begin
                    xfer.xfer_req   <= 1'b1;
                    xfer.xfer_rw    <= 1'b1;
                    xfer.xfer_addr  <= read_addr(idx);
                    xfer.xfer_wdata <= 8'h00;
                    tmo_cnt         <= '0;
                    state           <= RD_WAIT;
                end

                RD_WAIT: begin
                    if (xfer.xfer_ack) begin
                        xfer.xfer_req <= 1'b0;
                        shadow[idx]   <= xfer.xfer_rdata;
                        if (idx == READ_LAST) begin
                            idx   <= '0;
                            state <= UPDATE;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= RD_REQ;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        error         <= 1'b1;
                        xfer.xfer_req <= 1'b0;
                        init_done     <= 1'b0;
                        for (int i = 0; i < READ_COUNT; i++) begin
                            shadow[i] <= '0;
                        end
                        idx   <= '0;
                        state <= INIT_REQ;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                UPDATE: begin
                    // Only a complete burst reaches the outputs, low byte first
                    data_x      <= {shadow[1], shadow[0]};
                    data_y      <= {shadow[3], shadow[2]};
                    data_z      <= {shadow[5], shadow[4]};
                    data_update <= 1'b1;
                    state       <= IDLE;
                end

                default: begin
                    state <= INIT_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gsensor_sequencer.sv
// Directed bench for gsensor_sequencer with a byte-level shifter model.
module tb_gsensor_sequencer;

    localparam int CLK_FREQ    = 5000;
    localparam int UPDATE_FREQ = 50;    // divider of 100 cycles
    localparam int ACK_TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic signed [15:0] data_x, data_y, data_z;
    logic data_update, init_done, error;

    gsensor_sequencer_if bus ();

    gsensor_sequencer #(
        .CLK_FREQ    (CLK_FREQ),
        .UPDATE_FREQ (UPDATE_FREQ),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .xfer        (bus.master),
        .data_x      (data_x),
        .data_y      (data_y),
        .data_z      (data_z),
        .data_update (data_update),
        .init_done   (init_done),
        .error       (error)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Shifter model controls
    int         ack_delay = 3;
    logic [5:0] drop_addr = 6'h00;
    bit         drop_en   = 1'b0;
    bit         stray_req = 1'b0;
    logic [7:0] rd_tbl [6];

    // Transaction log and monitor state
    logic [5:0] log_addr [$];
    logic       log_rw   [$];
    logic [7:0] log_wd   [$];
    int         log_len  [$];
    int         rise32   [$];
    int         ccount = 0;
    int         cur_len = 0;
    int         n_upd = 0;
    int         ovl_err = 0;
    int         stab_err = 0;
    int         restart_err = 0;
    bit         req_q = 1'b0, ack_q = 1'b0, waiting = 1'b0, drop_cur = 1'b0;
    bit         in_set = 1'b0, err_q = 1'b0;
    logic [5:0] addr_q = '0;
    logic       rw_q = 1'b0;
    logic [7:0] wd_q = '0;

    logic [5:0] exp_init_addr [4] = '{6'h31, 6'h2C, 6'h2E, 6'h2D};
    logic [7:0] exp_init_data [4] = '{8'h40, 8'h09, 8'h00, 8'h08};

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Shifter model + bus monitor, evaluated on the falling edge
    initial begin
        bus.xfer_ack   = 1'b0;
        bus.xfer_rdata = 8'h00;
        forever begin
            @(negedge clk);
            bus.xfer_ack = 1'b0;
            if (!reset_n) begin
                req_q = 1'b0; ack_q = 1'b0; waiting = 1'b0; ccount = 0;
                in_set = 1'b0; err_q = 1'b0; cur_len = 0;
                if (stray_req) begin
                    bus.xfer_ack = 1'b1;
                    stray_req = 1'b0;
                end
            end else begin
                ccount++;
                if (data_update) begin
                    n_upd++;
                    in_set = 1'b0;
                end
                if (error && !err_q) in_set = 1'b0;
                err_q = error;
                if (ack_q && bus.xfer_req) ovl_err++;
                if (bus.xfer_req && req_q &&
                    (bus.xfer_addr != addr_q || bus.xfer_rw != rw_q || bus.xfer_wdata != wd_q))
                    stab_err++;
                if (!bus.xfer_req && req_q) log_len.push_back(cur_len);
                if (bus.xfer_req && !req_q) begin
                    log_addr.push_back(bus.xfer_addr);
                    log_rw.push_back(bus.xfer_rw);
                    log_wd.push_back(bus.xfer_wdata);
                    cur_len = 0;
                    waiting = 1'b1;
                    drop_cur = drop_en && (bus.xfer_addr == drop_addr);
                    if (drop_cur) drop_en = 1'b0;
                    if (bus.xfer_rw && bus.xfer_addr == 6'h32) begin
                        if (in_set) restart_err++;
                        in_set = 1'b1;
                        rise32.push_back(ccount);
                    end
                end
                if (bus.xfer_req) cur_len++;
                if (bus.xfer_req && waiting && !drop_cur && (cur_len - 1) >= ack_delay) begin
                    bus.xfer_ack = 1'b1;
                    if (bus.xfer_rw && bus.xfer_addr >= 6'h32 && bus.xfer_addr <= 6'h37)
                        bus.xfer_rdata = rd_tbl[int'(bus.xfer_addr) - 'h32];
                    else
                        bus.xfer_rdata = 8'h00;
                    waiting = 1'b0;
                end
                ack_q = bus.xfer_ack;
                req_q = bus.xfer_req;
                addr_q = bus.xfer_addr;
                rw_q = bus.xfer_rw;
                wd_q = bus.xfer_wdata;
            end
        end
    end

    task automatic wait_upd(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (data_update) seen = 1'b1;
        end
        #1;
    endtask

    task automatic wait_init(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (init_done) seen = 1'b1;
        end
        #1;
    endtask

    task automatic wait_err(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (error) seen = 1'b1;
        end
        #1;
    endtask

    task automatic wait_rise32(input int max_cyc, output bit seen);
        int n0;
        n0 = rise32.size();
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            #1;
            if (rise32.size() != n0) seen = 1'b1;
        end
    endtask

    initial begin
        bit ok;
        int n;
        rd_tbl = '{8'h10, 8'hFF, 8'h34, 8'h12, 8'h00, 8'h80};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_req", bus.xfer_req, 0);
        chk("rst_rw", bus.xfer_rw, 0);
        chk("rst_addr", bus.xfer_addr, 0);
        chk("rst_wdata", bus.xfer_wdata, 0);
        chk("rst_data_x", data_x, 0);
        chk("rst_data_y", data_y, 0);
        chk("rst_data_z", data_z, 0);
        chk("rst_update", data_update, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_error", error, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;

        // Configuration writes in order
        wait_init(300, ok);
        chk("init_seen", ok, 1);
        chk("init_log_len", log_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("init%0d_addr", i), log_addr[i], exp_init_addr[i]);
            chk($sformatf("init%0d_wdata", i), log_wd[i], exp_init_data[i]);
            chk($sformatf("init%0d_rw", i), log_rw[i], 0);
        end

        // First burst: starts three cycles after the first tick, samples signed
        wait_upd(400, ok);
        chk("upd1_seen", ok, 1);
        chk("first_rd_time", rise32[0], 102);
        chk("upd1_x", data_x, -240);
        chk("upd1_y", data_y, 16'h1234);
        chk("upd1_z", data_z, -32768);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rd%0d_addr", i), log_addr[4 + i], 6'h32 + i);
            chk($sformatf("rd%0d_rw", i), log_rw[4 + i], 1);
            chk($sformatf("rd%0d_wdata", i), log_wd[4 + i], 0);
        end
        @(negedge clk);
        chk("upd_pulse_width", data_update, 0);
        chk("upd_count", n_upd, 1);

        // Slow shifter: ticks pile up but collapse to one pending request
        ack_delay = 40;
        repeat (1200) @(negedge clk);
        ack_delay = 3;
        for (int k = 0; k < 3; k++) begin
            wait_upd(600, ok);
            chk($sformatf("drain_upd%0d", k), ok, 1);
        end
        for (int k = 0; k < 2; k++) begin
            wait_rise32(300, ok);
            chk($sformatf("tick_rd%0d_seen", k), ok, 1);
            chk($sformatf("tick_rd%0d_phase", k), rise32[rise32.size() - 1] % 100, 2);
        end

        // Ack on the last permitted cycle still completes the transaction
        rd_tbl = '{8'h01, 8'h00, 8'hFE, 8'hFF, 8'hFF, 8'h7F};
        ack_delay = ACK_TIMEOUT - 1;
        wait_upd(1500, ok);
        chk("late_upd1", ok, 1);
        wait_upd(1500, ok);
        chk("late_upd2", ok, 1);
        chk("late_error", error, 0);
        chk("late_len", log_len[log_len.size() - 1], ACK_TIMEOUT);
        chk("late_x", data_x, 1);
        chk("late_y", data_y, -2);
        chk("late_z", data_z, 32767);

        // Withheld ack on the third read: abort, keep old samples, re-init
        rd_tbl = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55};
        ack_delay = 3;
        drop_addr = 6'h34;
        drop_en = 1'b1;
        wait_err(600, ok);
        chk("tmo_error_seen", ok, 1);
        n = log_addr.size();
        chk("tmo_dropped_addr", log_addr[n - 1], 6'h34);
        chk("tmo_len", log_len[log_len.size() - 1], ACK_TIMEOUT);
        chk("tmo_req_low", bus.xfer_req, 0);
        chk("tmo_init_done", init_done, 0);
        chk("tmo_x_kept", data_x, 1);
        chk("tmo_y_kept", data_y, -2);
        chk("tmo_z_kept", data_z, 32767);
        wait_init(300, ok);
        chk("reinit_seen", ok, 1);
        chk("reinit_addr", log_addr[n], 6'h31);
        chk("reinit_wdata", log_wd[n], 8'h40);
        chk("reinit_rw", log_rw[n], 0);
        chk("error_sticky", error, 1);
        wait_upd(400, ok);
        chk("post_tmo_upd", ok, 1);
        chk("post_tmo_x", data_x, 16'h5555);

        // Reset during a read wait, stray ack straight after release
        ack_delay = 20;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (bus.xfer_req && log_addr[log_addr.size() - 1] == 6'h33) ok = 1'b1;
        end
        chk("rd33_seen", ok, 1);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_req", bus.xfer_req, 0);
        chk("async_x", data_x, 0);
        chk("async_init_done", init_done, 0);
        chk("async_error", error, 0);
        stray_req = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        n = log_addr.size();
        wait_init(300, ok);
        chk("rst_reinit_seen", ok, 1);
        chk("rst_first_addr", log_addr[n], 6'h31);
        chk("rst_first_wdata", log_wd[n], 8'h40);
        chk("rst_error_after", error, 0);

        // Protocol monitors over the whole run
        chk("no_overlap", ovl_err, 0);
        chk("stable_while_req", stab_err, 0);
        chk("restart_after_idle", restart_err, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
